// File: rtl/serial_to_parallel_rx.sv
// Serial-to-parallel receiver: assembles qualified serial bits into WIDTH-bit words
// and holds one completed word behind a valid/ready handshake, flagging dropped words.
module serial_to_parallel_rx #(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_i,
  input  logic             valid_i,
  input  logic             clear_i,
  output logic [WIDTH-1:0] parallel_o,
  output logic             pvalid_o,
  input  logic             pready_i,
  output logic             busy_o,
  output logic             overflow_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_word;
  logic             r_pvalid;
  logic             r_overflow;

  logic             w_accept;
  logic             w_last;
  logic             w_consume;
  logic [WIDTH-1:0] w_shift_next;

  assign w_accept  = valid_i & ~clear_i;
  assign w_last    = w_accept & (r_count == LAST_BIT);
  assign w_consume = r_pvalid & pready_i;

  generate
    if (LSB_FIRST) begin : g_lsb_first
      assign w_shift_next = {serial_i, r_shift[WIDTH-1:1]};
    end else begin : g_msb_first
      assign w_shift_next = {r_shift[WIDTH-2:0], serial_i};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count    <= '0;
      r_shift    <= '0;
      r_word     <= '0;
      r_pvalid   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (clear_i) begin
        r_count <= '0;
        r_shift <= '0;
      end else if (w_accept) begin
        r_shift <= w_shift_next;
        r_count <= w_last ? '0 : r_count + CW'(1);
      end

      // A word consumed on the completion edge frees the register for the new word.
      if (w_last) begin
        if (!r_pvalid || w_consume) begin
          r_word   <= w_shift_next;
          r_pvalid <= 1'b1;
        end else begin
          r_overflow <= 1'b1;
        end
      end else if (w_consume) begin
        r_pvalid <= 1'b0;
      end
    end
  end

  assign parallel_o = r_word;
  assign pvalid_o   = r_pvalid;
  assign busy_o     = (r_count != '0);
  assign overflow_o = r_overflow;

endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// Scoreboard bench for serial_to_parallel_rx: one LSB-first and one MSB-first instance,
// expected words queued at stimulus time and compared when the consumer takes them.
module tb_serial_to_parallel_rx;

  logic clk = 1'b0;
  logic reset;

  logic       a_ser, a_val, a_clr, a_rdy;
  logic [3:0] a_par;
  logic       a_pv, a_busy, a_ovf;
  logic       b_ser, b_val, b_clr, b_rdy;
  logic [3:0] b_par;
  logic       b_pv, b_busy, b_ovf;

  int n_checks = 0;
  int n_errors = 0;
  logic [3:0] q_a[$];
  logic [3:0] q_b[$];

  always #5 clk = ~clk;

  serial_to_parallel_rx #(.WIDTH(4), .LSB_FIRST(1'b1)) dut_a (
    .clk(clk), .reset(reset), .serial_i(a_ser), .valid_i(a_val), .clear_i(a_clr),
    .parallel_o(a_par), .pvalid_o(a_pv), .pready_i(a_rdy), .busy_o(a_busy), .overflow_o(a_ovf)
  );

  serial_to_parallel_rx #(.WIDTH(4), .LSB_FIRST(1'b0)) dut_b (
    .clk(clk), .reset(reset), .serial_i(b_ser), .valid_i(b_val), .clear_i(b_clr),
    .parallel_o(b_par), .pvalid_o(b_pv), .pready_i(b_rdy), .busy_o(b_busy), .overflow_o(b_ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Consumer side: every accepted word must match the oldest expected word.
  always @(negedge clk) begin
    if (!reset && a_pv && a_rdy) begin
      if (q_a.size() == 0) check("sb_a_underflow", 32'd1, 32'd0);
      else check("sb_word_a", {28'd0, a_par}, {28'd0, q_a.pop_front()});
    end
    if (!reset && b_pv && b_rdy) begin
      if (q_b.size() == 0) check("sb_b_underflow", 32'd1, 32'd0);
      else check("sb_word_b", {28'd0, b_par}, {28'd0, q_b.pop_front()});
    end
  end

  task automatic send_bit(input bit sel, input logic b);
    if (sel) begin b_ser = b; b_val = 1'b1; end
    else begin a_ser = b; a_val = 1'b1; end
    step();
    a_val = 1'b0;
    b_val = 1'b0;
  endtask

  task automatic send_word(input bit sel, input logic [3:0] w, input bit keep);
    logic bit_v;
    for (int i = 0; i < 4; i++) begin
      bit_v = sel ? w[3-i] : w[i];
      send_bit(sel, bit_v);
      check(sel ? "busy_b" : "busy_a", {31'd0, sel ? b_busy : a_busy}, {31'd0, (i != 3)});
    end
    check(sel ? "pvalid_b_done" : "pvalid_a_done", {31'd0, sel ? b_pv : a_pv}, 32'd1);
    if (keep) begin
      if (sel) q_b.push_back(w);
      else q_a.push_back(w);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t expected below 100000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    {a_ser, a_val, a_clr, a_rdy} = '0;
    {b_ser, b_val, b_clr, b_rdy} = '0;
    step();
    step();
    reset = 1'b0;
    check("rst_par_a", {28'd0, a_par}, 32'd0);
    check("rst_pv_a", {31'd0, a_pv}, 32'd0);
    check("rst_busy_a", {31'd0, a_busy}, 32'd0);
    check("rst_ovf_a", {31'd0, a_ovf}, 32'd0);
    check("rst_pv_b", {31'd0, b_pv}, 32'd0);

    // Contiguous 1,0,1,1 -> D
    send_word(1'b0, 4'hD, 1'b1);
    check("word_d_direct", {28'd0, a_par}, 32'hD);
    a_rdy = 1'b1; step(); a_rdy = 1'b0;
    check("pv_after_consume", {31'd0, a_pv}, 32'd0);

    // Same stream with a 2-cycle gap after bit 2
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b0);
    for (int g = 0; g < 2; g++) begin
      step();
      check("gap_busy", {31'd0, a_busy}, 32'd1);
      check("gap_pv", {31'd0, a_pv}, 32'd0);
    end
    send_bit(1'b0, 1'b1);
    check("gap_pv_bit3", {31'd0, a_pv}, 32'd0);
    send_bit(1'b0, 1'b1);
    check("gap_pv_bit4", {31'd0, a_pv}, 32'd1);
    q_a.push_back(4'hD);
    for (int h = 0; h < 5; h++) begin
      step();
      check("hold_par", {28'd0, a_par}, 32'hD);
      check("hold_pv", {31'd0, a_pv}, 32'd1);
    end
    a_rdy = 1'b1; step(); a_rdy = 1'b0;
    check("hold_release_pv", {31'd0, a_pv}, 32'd0);

    // Back-to-back words with consumer always ready
    a_rdy = 1'b1;
    send_word(1'b0, 4'hF, 1'b1);
    send_word(1'b0, 4'h0, 1'b1);
    step();
    a_rdy = 1'b0;
    check("b2b_pv", {31'd0, a_pv}, 32'd0);
    check("b2b_ovf", {31'd0, a_ovf}, 32'd0);

    // Overflow: A held, 5 dropped
    send_word(1'b0, 4'hA, 1'b1);
    check("ovf_before", {31'd0, a_ovf}, 32'd0);
    send_word(1'b0, 4'h5, 1'b0);
    check("ovf_par_kept", {28'd0, a_par}, 32'hA);
    check("ovf_set", {31'd0, a_ovf}, 32'd1);
    a_rdy = 1'b1; step(); a_rdy = 1'b0;
    check("ovf_consumed_pv", {31'd0, a_pv}, 32'd0);
    step(); step();
    check("ovf_sticky", {31'd0, a_ovf}, 32'd1);

    // Clear after 2 bits, colliding with a valid bit
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b1);
    a_clr = 1'b1; a_val = 1'b1; a_ser = 1'b1;
    step();
    a_clr = 1'b0; a_val = 1'b0;
    check("clear_busy", {31'd0, a_busy}, 32'd0);
    send_word(1'b0, 4'h6, 1'b1);
    check("clear_word", {28'd0, a_par}, 32'h6);
    a_rdy = 1'b1; step(); a_rdy = 1'b0;

    // MSB-first instance: 1,0,0,0 -> 8
    send_word(1'b1, 4'h8, 1'b1);
    check("msb_word", {28'd0, b_par}, 32'h8);
    b_rdy = 1'b1; step(); b_rdy = 1'b0;

    // Reset mid-word
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    reset = 1'b1; step(); reset = 1'b0;
    check("rst_mid_busy", {31'd0, b_busy}, 32'd0);
    check("rst_mid_pv", {31'd0, b_pv}, 32'd0);
    check("rst_clears_ovf_a", {31'd0, a_ovf}, 32'd0);

    // Reset while holding a word
    send_word(1'b1, 4'h3, 1'b0);
    reset = 1'b1; step(); reset = 1'b0;
    check("rst_hold_pv", {31'd0, b_pv}, 32'd0);
    check("rst_hold_par", {28'd0, b_par}, 32'd0);
    check("rst_hold_ovf", {31'd0, b_ovf}, 32'd0);
    send_word(1'b1, 4'h7, 1'b1);
    check("post_rst_word", {28'd0, b_par}, 32'h7);
    b_rdy = 1'b1; step(); b_rdy = 1'b0;
    step();

    check("sb_a_drained", q_a.size(), 32'd0);
    check("sb_b_drained", q_b.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/serial_to_parallel_rx.md
Name: serial_to_parallel_rx

Overview:
Receive-side counterpart of the team's 4-bit parallel-to-serial transmitter. Collects a qualified serial bit stream into WIDTH-bit words and presents each word on a valid/ready parallel interface. Holds one completed word in an output register and flags overflow when a new word completes while that register is still full. Sits between a serial link (or the transmitter in loopback) and a word-oriented consumer.

Parameters:
WIDTH, 4, bits per word; legal range is WIDTH >= 2.
LSB_FIRST, 1, 1 = first received bit lands in parallel_o[0] (matches the transmitter, which shifts bit 0 out first); 0 = first bit lands in parallel_o[WIDTH-1].

Ports:
clk  input  1  clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
serial_i  input  1  serial data bit; sampled only when valid_i=1.
valid_i  input  1  qualifies serial_i for the current cycle.
clear_i  input  1  synchronous abort of the partial word being assembled.
parallel_o  output  WIDTH  completed word, held stable while pvalid_o=1.
pvalid_o  output  1  parallel_o holds an unconsumed word.
pready_i  input  1  consumer accepts the word; transfer happens when pvalid_o & pready_i.
busy_o  output  1  partial word in progress (bit count != 0).
overflow_o  output  1  sticky: a completed word was dropped.

Behaviour:
- Reset (sync, active-high): parallel_o=0, pvalid_o=0, busy_o=0, overflow_o=0, shift register=0, bit count=0. Reset overrides every other input. Reset mid-word discards the partial word and any held word.
- Bit count is a register of width $clog2(WIDTH+1). It ranges 0..WIDTH-1 and increments on each accepted bit (valid_i=1, clear_i=0).
- Gaps in valid_i are legal: count and shift register hold, and bits need not be contiguous.
- Assembly, LSB_FIRST=1: shift register shifts right, and the new bit enters at [WIDTH-1]. After WIDTH bits, the first bit is at [0].
- Assembly, LSB_FIRST=0: shift register shifts left, and the new bit enters at [0].
- Completion: on the edge that accepts the WIDTH-th bit, count wraps to 0 and the assembled word (including that bit) is the candidate for the output register.
- Latency: pvalid_o rises on the cycle after the last bit is sampled.
- Output handshake: word consumed on the edge where pvalid_o=1 and pready_i=1. pvalid_o then clears unless a new word loads on the same edge.
- While pvalid_o=1 and pready_i=0, parallel_o must not change.
- Completion with output empty, or with output consumed on the same edge: load the word, pvalid_o=1 next cycle. This gives back-to-back words with no bubble.
- Completion with output full and not consumed on that edge: drop the new word, keep the held word, and set overflow_o=1. overflow_o stays set until reset.
- clear_i=1: count=0 and shift register=0 next cycle. Any valid_i bit in the same cycle is discarded (clear wins). The output register, pvalid_o and overflow_o are unaffected.
- busy_o = (count != 0), derived combinationally from the count register.
- pready_i has no effect when pvalid_o=0.
- No combinational path from serial_i or valid_i to any output.

Test Plan:
- WIDTH=4, LSB_FIRST=1: valid_i=1 for 4 consecutive cycles with serial_i=1,0,1,1 -> cycle after 4th bit: pvalid_o=1, parallel_o=4'hD. busy_o=1 after bits 1-3 and 0 after bit 4.
- Same stream with valid_i low for 2 cycles between bits 2 and 3 -> parallel_o=4'hD, delayed by exactly 2 cycles. Then pready_i=0 for 5 cycles -> parallel_o stays 4'hD and pvalid_o stays 1. pready_i=1 -> pvalid_o=0 next cycle.
- pready_i held 1, continuous stream 1,1,1,1,0,0,0,0 -> words 4'hF then 4'h0 on consecutive 4-cycle boundaries, with no overflow.
- pready_i=0, stream 4'hA then 4'h5 -> parallel_o stays 4'hA and overflow_o=1 the cycle after the 8th bit. Then pready_i=1 -> 4'hA consumed, overflow_o stays 1 until reset.
- clear_i asserted after 2 bits, together with a valid bit -> busy_o=0 next cycle. The following 4 bits 0,1,1,0 produce 4'h6, with no stale bits.
- LSB_FIRST=0: bits 1,0,0,0 -> parallel_o=4'h8. Reset asserted mid-word and mid-hold -> all outputs 0 next cycle, and the next full word is received correctly.
